l2_req_ctrl: RTL and testbench

Downstream stage of the coherence bus controller's L2 port. It takes the controller's single-word L2 read and write requests, drives them onto the generic memory-side port with a registered request/busy handshake, and reports progress back as `l2_state_t`. It owns request latching, response capture, error reporting and an optional stall watchdog. This gives the bus controller one well-defined L2 model for both synthesis and bench use.

---
 rtl/l2_req_ctrl_pkg.sv | 19 +
 rtl/l2_req_watchdog.sv | 28 ++
 rtl/l2_req_ctrl.sv | 116 +++++++++++
 tb/tb_l2_req_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_req_ctrl_pkg.sv
// Shared bus types for the L2 request path: data word, L2 progress state and
// the FSM state encoding (the FSM state register is exported as l2state).
package l2_req_ctrl_pkg;

  typedef logic [31:0] bus_word_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  // The controller FSM walks exactly the states it reports, so one encoding serves both.
  typedef l2_state_t l2_fsm_state_t;

  localparam int unsigned WD_CNT_W = 16;

endpackage

// File: rtl/l2_req_watchdog.sv
// Stall watchdog for the L2 request FSM: counts memory-busy cycles and flags
// expiry on the cycle the count reaches TIMEOUT. Built only with L2_REQ_TIMEOUT_EN.
module l2_req_watchdog
  import l2_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WD_CNT_W-1:0] count;

  // Expiry fires on the busy cycle that would bring the count up to TIMEOUT.
  assign expired = count_en && (count == WD_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || expired) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + WD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/l2_req_ctrl.sv
// L2 request controller: turns single-word L2 read/write requests into a
// registered strobe/busy memory transfer. Define L2_REQ_TIMEOUT_EN to add the stall watchdog.
module l2_req_ctrl
  import l2_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT        = 256,
  parameter int          ADDR_ALIGN_CHK = 1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      l2REN,
  input  logic      l2WEN,
  input  bus_word_t l2addr,
  input  bus_word_t l2store,
  output l2_state_t l2state,
  output bus_word_t l2load,
  output bus_word_t mem_addr,
  output logic      mem_ren,
  output logic      mem_wen,
  output bus_word_t mem_wdata,
  input  bus_word_t mem_rdata,
  input  logic      mem_busy
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("l2_req_ctrl: TIMEOUT must lie in 2..65535");
  end

  // Memory handshake: a strobe (mem_ren/mem_wen) is held with stable mem_addr and
  // mem_wdata for the whole of BUSY; the transfer completes on the first rising
  // edge where a strobe is high and mem_busy is 0, and the strobe drops at that edge.

  l2_fsm_state_t state_d;
  logic          req_any;
  logic          req_conflict;
  logic          addr_bad;
  logic          start;
  logic          done;
  logic          abort;
  logic          wd_expired;

  assign req_any      = l2REN ^ l2WEN;
  assign req_conflict = l2REN & l2WEN;
  assign addr_bad     = (ADDR_ALIGN_CHK != 0) && (l2addr[1:0] != 2'b00);

`ifdef L2_REQ_TIMEOUT_EN
  l2_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RST),
    .clear    (start),
    .count_en ((l2state == L2_BUSY) && mem_busy),
    .expired  (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = l2state;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (l2state)
      L2_FREE: begin
        if (req_conflict || (req_any && addr_bad)) begin
          state_d = L2_ERROR;
        end else if (req_any) begin
          state_d = L2_BUSY;
          start   = 1'b1;
        end
      end
      L2_BUSY: begin
        if (!mem_busy) begin
          state_d = L2_ACCESS;
          done    = 1'b1;
        end else if (wd_expired) begin
          state_d = L2_ERROR;
          abort   = 1'b1;
        end
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR:  state_d = L2_FREE;
      default:   state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      l2state   <= L2_FREE;
      l2load    <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      l2state <= state_d;
      if (start) begin
        mem_addr  <= l2addr;
        mem_wdata <= l2store;
        mem_ren   <= l2REN;
        mem_wen   <= l2WEN;
      end
      if (done || abort) begin
        mem_ren <= 1'b0;
        mem_wen <= 1'b0;
      end
      // The latched read strobe doubles as the transfer direction.
      if (done && mem_ren) begin
        l2load <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_l2_req_ctrl.sv
// Self-checking bench for l2_req_ctrl: transaction-level model with a memory
// array and an expected-read queue; covers both builds of L2_REQ_TIMEOUT_EN.
module tb_l2_req_ctrl;
  import l2_req_ctrl_pkg::*;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef L2_REQ_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [31:0] l2store;
  l2_state_t   l2state;
  logic [31:0] l2load;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  l2_req_ctrl #(
    .TIMEOUT        (TB_TIMEOUT),
    .ADDR_ALIGN_CHK (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .l2REN     (l2REN),
    .l2WEN     (l2WEN),
    .l2addr    (l2addr),
    .l2store   (l2store),
    .l2state   (l2state),
    .l2load    (l2load),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] exp_load;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_state(input string tag, input l2_state_t exp_st);
    check_eq({tag, ".state"}, 32'(l2state), 32'(exp_st));
  endtask

  task automatic check_no_strobe(input string tag);
    check_eq({tag, ".ren"}, 32'(mem_ren), 32'd0);
    check_eq({tag, ".wen"}, 32'(mem_wen), 32'd0);
  endtask

  // ---------------- driver ----------------
  // One request issued from FREE; called and returns at a falling edge.
  // stalls = number of mem_busy cycles before completion. hold keeps the
  // request asserted through BUSY/ACCESS and moves l2addr to new_addr.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int stalls, input bit hold,
                        input logic [31:0] new_addr);
    logic err;
    bit   to;
    int   busy_cycles;
    l2REN     = rd;
    l2WEN     = wr;
    l2addr    = addr;
    l2store   = data;
    mem_busy  = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    err = (rd && wr) || ((rd || wr) && (addr[1:0] != 2'b00));
    if (rd && !err) begin
      if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
      exp_q.push_back(mem_model[addr]);
    end
    step();
    if (hold) begin
      l2addr = new_addr;
    end else begin
      l2REN   = 1'b0;
      l2WEN   = 1'b0;
      l2addr  = $urandom;
      l2store = $urandom;
    end
    if (!rd && !wr) begin
      check_state("idle", L2_FREE);
      check_no_strobe("idle");
      return;
    end
    if (err) begin
      check_state("req_err", L2_ERROR);
      check_no_strobe("req_err");
      check_eq("req_err.load", l2load, exp_load);
      step();
      check_state("req_err_after", L2_FREE);
      check_no_strobe("req_err_after");
      return;
    end
    to          = WD_ON && (stalls >= int'(TB_TIMEOUT));
    busy_cycles = to ? int'(TB_TIMEOUT) : stalls + 1;
    for (int k = 0; k < busy_cycles; k++) begin
      check_state("busy", L2_BUSY);
      check_eq("busy.ren", 32'(mem_ren), 32'(rd));
      check_eq("busy.wen", 32'(mem_wen), 32'(wr));
      check_eq("busy.addr", mem_addr, addr);
      check_eq("busy.wdata", mem_wdata, data);
      mem_busy  = to ? 1'b1 : (k < stalls);
      mem_rdata = (mem_busy || !rd) ? $urandom : mem_model[addr];
      step();
    end
    if (to) begin
      check_state("timeout", L2_ERROR);
      check_no_strobe("timeout");
      check_eq("timeout.load", l2load, exp_load);
      if (rd) void'(exp_q.pop_front());
    end else begin
      check_state("access", L2_ACCESS);
      check_no_strobe("access");
      if (rd) exp_load = exp_q.pop_front();
      if (wr) mem_model[addr] = data;
      check_eq("access.load", l2load, exp_load);
    end
    mem_busy = 1'($urandom_range(0, 1));
    step();
    check_state("after", L2_FREE);
    check_no_strobe("after");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        rd;
    logic        wr;
    logic [31:0] a;
    int          kind;
    RST       = 1'b1;
    l2REN     = 1'b0;
    l2WEN     = 1'b0;
    l2addr    = '0;
    l2store   = '0;
    mem_rdata = '0;
    mem_busy  = 1'b0;
    exp_load  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_state("reset", L2_FREE);
    check_no_strobe("reset");
    check_eq("reset.load", l2load, 32'h0);
    check_eq("reset.addr", mem_addr, 32'h0);
    check_eq("reset.wdata", mem_wdata, 32'h0);
    RST = 1'b0;

    mem_model[32'h0000_1000] = 32'hDEAD_BEEF;
    do_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0000_2004, 32'h1234_5678, 5, 1'b0, 32'h0);
    do_txn(1'b1, 1'b1, 32'h0000_2008, 32'h5555_AAAA, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 32'h0000_0003, 32'h0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h0000_0006, 32'h0BAD_F00D, 0, 1'b0, 32'h0);

    // Reset asserted for one cycle in the middle of a stalled read.
    l2REN    = 1'b1;
    l2addr   = 32'h0000_3000;
    mem_busy = 1'b1;
    step();
    l2REN = 1'b0;
    check_state("rst_mid.busy", L2_BUSY);
    check_eq("rst_mid.ren", 32'(mem_ren), 32'd1);
    step();
    check_state("rst_mid.busy2", L2_BUSY);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_state("rst_mid.after", L2_FREE);
    check_no_strobe("rst_mid.after");
    check_eq("rst_mid.load", l2load, 32'h0);
    exp_load = '0;
    do_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1, 1'b0, 32'h0);

    // Memory stuck busy: watchdog build errors out, plain build keeps waiting.
    do_txn(1'b1, 1'b0, 32'h0000_3004, 32'h0, 12, 1'b0, 32'h0);

    // Request held through ACCESS with the address changed during BUSY.
    do_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1, 1'b1, 32'h0000_4008);
    do_txn(1'b1, 1'b0, 32'h0000_4008, 32'h0, 0, 1'b0, 32'h0);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind < 4) || (kind == 8);
      wr   = ((kind >= 4) && (kind < 8)) || (kind == 8);
      a    = 32'h0000_5000 + 32'($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      do_txn(rd, wr, a, $urandom, $urandom_range(0, 6), 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1, "bench time limit expired");
  end

endmodule
